// File: rtl/run_sequencer.sv
// run_sequencer: launches NUM_PROGS programs back to back on an external
// processor, one after another, and reports how long each one ran.
//
// Ports:
//   i_clk        - single clock, all state updates on its rising edge
//   i_rst        - asynchronous active-high reset
//   i_go         - begins a batch when sampled high while idle
//   i_abort      - synchronously ends the batch and returns to idle
//   i_ack        - done flag from the processor
//   o_start      - start request to the processor (registered)
//   o_prog_idx   - index of the program being launched or run
//   o_busy       - high whenever the sequencer is not idle
//   o_run_done   - one-cycle pulse at the end of each program (registered)
//   o_cycles     - run-cycle count of the most recently finished program
//   o_timed_out  - sticky: some program of the current batch timed out
//   o_batch_done - one-cycle pulse when the last program finishes (registered)
//   o_state      - current FSM state, for debug and checkers
//
// Start/Ack handshake: o_start is held high for exactly START_CYCLES cycles
// per launch; Ack is ignored during that window because the processor may
// still be showing the done flag of the previous run. From the first cycle
// after o_start falls, every cycle with Ack low adds one to the run count,
// and the first cycle sampled with Ack high ends the run. If the count
// reaches TIMEOUT with Ack still low the run is abandoned.
module run_sequencer #(
  parameter int          NUM_PROGS    = 3,
  parameter int          START_CYCLES = 2,
  parameter logic [15:0] TIMEOUT      = 16'd10000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_go,
  input  logic        i_abort,
  input  logic        i_ack,
  output logic        o_start,
  output logic [1:0]  o_prog_idx,
  output logic        o_busy,
  output logic        o_run_done,
  output logic [15:0] o_cycles,
  output logic        o_timed_out,
  output logic        o_batch_done,
  output logic [1:0]  o_state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_RUN    = 2'd2,
    S_NEXT   = 2'd3
  } state_t;

  localparam int            LW          = (START_CYCLES > 1) ? $clog2(START_CYCLES) : 1;
  localparam logic [LW-1:0] LAUNCH_LAST = LW'(START_CYCLES - 1);
  localparam logic [1:0]    LAST_PROG   = 2'(NUM_PROGS - 1);

  state_t          r_state;
  logic [LW-1:0]   r_launch_cnt;
  logic [15:0]     r_run_cnt;
  logic            r_start;
  logic [1:0]      r_prog_idx;
  logic            r_run_done;
  logic [15:0]     r_cycles;
  logic            r_timed_out;
  logic            r_batch_done;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_launch_cnt <= '0;
      r_run_cnt    <= '0;
      r_start      <= 1'b0;
      r_prog_idx   <= 2'd0;
      r_run_done   <= 1'b0;
      r_cycles     <= 16'd0;
      r_timed_out  <= 1'b0;
      r_batch_done <= 1'b0;
    end else begin
      // Pulses default low; they are only raised for a single cycle below.
      r_run_done   <= 1'b0;
      r_batch_done <= 1'b0;
      if (i_abort) begin
        // Abort outranks everything, including Go in idle and Ack in run.
        // Cycles and TimedOut deliberately keep their values.
        r_state <= S_IDLE;
        r_start <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (i_go) begin
              r_state      <= S_LAUNCH;
              r_prog_idx   <= 2'd0;
              r_timed_out  <= 1'b0;
              r_start      <= 1'b1;
              r_launch_cnt <= '0;
            end
          end
          S_LAUNCH: begin
            if (r_launch_cnt == LAUNCH_LAST) begin
              r_state   <= S_RUN;
              r_start   <= 1'b0;
              r_run_cnt <= 16'd0;
            end else begin
              r_launch_cnt <= r_launch_cnt + LW'(1);
            end
          end
          S_RUN: begin
            // Ack is checked first so that it wins a tie with the timeout.
            if (i_ack) begin
              r_cycles   <= r_run_cnt;
              r_run_done <= 1'b1;
              r_state    <= S_NEXT;
            end else if (r_run_cnt == TIMEOUT) begin
              r_cycles    <= TIMEOUT;
              r_timed_out <= 1'b1;
              r_run_done  <= 1'b1;
              r_state     <= S_NEXT;
            end else if (r_run_cnt != 16'hFFFF) begin
              r_run_cnt <= r_run_cnt + 16'd1;
            end
          end
          S_NEXT: begin
            if (r_prog_idx == LAST_PROG) begin
              r_batch_done <= 1'b1;
              r_state      <= S_IDLE;
            end else begin
              r_prog_idx   <= r_prog_idx + 2'd1;
              r_state      <= S_LAUNCH;
              r_start      <= 1'b1;
              r_launch_cnt <= '0;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign o_start      = r_start;
  assign o_prog_idx   = r_prog_idx;
  assign o_busy       = (r_state != S_IDLE);
  assign o_run_done   = r_run_done;
  assign o_cycles     = r_cycles;
  assign o_timed_out  = r_timed_out;
  assign o_batch_done = r_batch_done;
  assign o_state      = r_state;

endmodule

// File: tb/tb_run_sequencer.sv
// Bench for run_sequencer: a reactive processor model raises Ack a chosen
// number of run cycles after Start falls; expected per-program cycle counts,
// timeout flags and launch indices come from the delay list alone.
module tb_run_sequencer;

  localparam int NUM_PROGS    = 3;
  localparam int START_CYCLES = 2;
  localparam int TIMEOUT      = 50;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        go, abort, ack;
  logic        o_start, o_busy, o_run_done, o_timed_out, o_batch_done;
  logic [1:0]  o_prog_idx, o_state;
  logic [15:0] o_cycles;

  run_sequencer #(
    .NUM_PROGS   (NUM_PROGS),
    .START_CYCLES(START_CYCLES),
    .TIMEOUT     (16'(TIMEOUT))
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_go        (go),
    .i_abort     (abort),
    .i_ack       (ack),
    .o_start     (o_start),
    .o_prog_idx  (o_prog_idx),
    .o_busy      (o_busy),
    .o_run_done  (o_run_done),
    .o_cycles    (o_cycles),
    .o_timed_out (o_timed_out),
    .o_batch_done(o_batch_done),
    .o_state     (o_state)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // ---------------- batch configuration ----------------
  int cfg_d [NUM_PROGS];   // Ack-low run cycles before Ack rises
  bit cfg_stale;           // Ack left high outside RUN (stale done flag)
  int cfg_abort_prog;      // program to abort (-1: none)
  int cfg_abort_cyc;       // run cycle at which abort is driven
  int cfg_rst_prog;        // program whose launch gets an async reset (-1: none)
  bit cfg_go_busy;         // pulse Go while busy during program 0

  task automatic set_cfg(input int d0, input int d1, input int d2, input bit stale,
                         input int ab_prog, input int ab_cyc, input int rs_prog,
                         input bit go_busy);
    cfg_d[0] = d0; cfg_d[1] = d1; cfg_d[2] = d2;
    cfg_stale      = stale;
    cfg_abort_prog = ab_prog;
    cfg_abort_cyc  = ab_cyc;
    cfg_rst_prog   = rs_prog;
    cfg_go_busy    = go_busy;
  endtask

  // ---------------- driver + checker for one batch ----------------
  task automatic run_batch(input string name);
    int p, run_cyc, start_len;
    logic [15:0] last_cyc;
    bit in_run, done, any_to;
    bit exp_to [NUM_PROGS];
    p = 0; run_cyc = 0; start_len = 0; last_cyc = 16'd0;
    in_run = 0; done = 0; any_to = 0;
    exp_q.delete();
    for (int i = 0; i < NUM_PROGS; i++) begin
      exp_to[i] = (cfg_d[i] > TIMEOUT);
      exp_q.push_back(exp_to[i] ? 16'(TIMEOUT) : 16'(cfg_d[i]));
    end

    @(negedge clk);
    go  = 1'b1;
    ack = cfg_stale;
    for (int cyc = 0; cyc < 1000 && !done; cyc++) begin
      @(negedge clk);
      go = 1'b0;
      // ---- observe ----
      if (o_run_done) begin
        check_eq({name, "/rd_in_run"}, 32'(in_run), 1);
        check_eq({name, "/rd_idx"}, 32'(o_prog_idx), p);
        if (p < NUM_PROGS) begin
          check_eq({name, "/rd_latency"}, run_cyc, exp_q[0] + 1);
          last_cyc = exp_q.pop_front();
          check_eq({name, "/cycles"}, 32'(o_cycles), 32'(last_cyc));
          any_to = any_to | exp_to[p];
          check_eq({name, "/timed_out"}, 32'(o_timed_out), 32'(any_to));
        end
        in_run = 0;
        p++;
      end
      if (o_batch_done) begin
        check_eq({name, "/bd_progs"}, p, NUM_PROGS);
        check_eq({name, "/bd_busy"}, 32'(o_busy), 0);
        check_eq({name, "/bd_timed_out"}, 32'(o_timed_out), 32'(any_to));
        done = 1;
      end
      if (o_start) begin
        if (start_len == 0) check_eq({name, "/launch_idx"}, 32'(o_prog_idx), p);
        start_len++;
        if (p == cfg_rst_prog && start_len == 1) begin
          @(posedge clk);
          #1;
          check_eq({name, "/pre_rst_start"}, 32'(o_start), 1);
          #1;
          rst = 1'b1;
          #1;
          check_eq({name, "/rst_start"}, 32'(o_start), 0);
          check_eq({name, "/rst_busy"}, 32'(o_busy), 0);
          check_eq({name, "/rst_idx"}, 32'(o_prog_idx), 0);
          check_eq({name, "/rst_rd"}, 32'(o_run_done), 0);
          check_eq({name, "/rst_bd"}, 32'(o_batch_done), 0);
          check_eq({name, "/rst_cycles"}, 32'(o_cycles), 0);
          check_eq({name, "/rst_to"}, 32'(o_timed_out), 0);
          @(negedge clk);
          rst = 1'b0;
          ack = 1'b0;
          repeat (6) begin
            @(negedge clk);
            check_eq({name, "/rst_no_relaunch"}, 32'(o_busy), 0);
            check_eq({name, "/rst_no_start"}, 32'(o_start), 0);
          end
          done = 1;
        end
      end else if (start_len != 0) begin
        check_eq({name, "/start_len"}, start_len, START_CYCLES);
        start_len = 0;
        in_run    = 1;
        run_cyc   = 0;
      end
      // ---- processor model and control inputs ----
      if (!done) begin
        if (in_run) begin
          ack = (run_cyc >= cfg_d[p]);
          run_cyc++;
        end else begin
          ack = cfg_stale;
        end
        if (cfg_go_busy && p == 0 && in_run && run_cyc == 4) go = 1'b1;
        if (p == cfg_abort_prog && in_run && run_cyc == cfg_abort_cyc + 1) begin
          abort = 1'b1;
          @(negedge clk);
          abort = 1'b0;
          ack   = 1'b0;
          check_eq({name, "/ab_busy"}, 32'(o_busy), 0);
          check_eq({name, "/ab_start"}, 32'(o_start), 0);
          check_eq({name, "/ab_rd"}, 32'(o_run_done), 0);
          check_eq({name, "/ab_cycles"}, 32'(o_cycles), 32'(last_cyc));
          check_eq({name, "/ab_to"}, 32'(o_timed_out), 32'(any_to));
          repeat (10) begin
            @(negedge clk);
            check_eq({name, "/ab_idle"}, 32'(o_busy), 0);
            check_eq({name, "/ab_no_bd"}, 32'(o_batch_done), 0);
          end
          done = 1;
        end
      end
    end
    check_eq({name, "/finished"}, 32'(done), 1);
    ack = 1'b0;
    @(negedge clk);
    check_eq({name, "/bd_one_cycle"}, 32'(o_batch_done), 0);
    check_eq({name, "/stays_idle"}, 32'(o_busy), 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b1; go = 1'b0; abort = 1'b0; ack = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("reset/start", 32'(o_start), 0);
    check_eq("reset/busy", 32'(o_busy), 0);
    check_eq("reset/idx", 32'(o_prog_idx), 0);
    check_eq("reset/rd", 32'(o_run_done), 0);
    check_eq("reset/bd", 32'(o_batch_done), 0);
    check_eq("reset/cycles", 32'(o_cycles), 0);
    check_eq("reset/to", 32'(o_timed_out), 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("reset/no_launch", 32'(o_busy), 0);

    set_cfg(20, 20, 20, 0, -1, 0, -1, 0);   run_batch("nominal");
    set_cfg(5, 5, 5, 1, -1, 0, -1, 0);      run_batch("stale_ack");
    set_cfg(20, 1000, 20, 0, -1, 0, -1, 0); run_batch("timeout");
    set_cfg(50, 50, 50, 0, -1, 0, -1, 0);   run_batch("race");

    // Go and Abort together in idle: abort wins.
    @(negedge clk);
    go = 1'b1; abort = 1'b1;
    @(negedge clk);
    go = 1'b0; abort = 1'b0;
    check_eq("go_abort/busy", 32'(o_busy), 0);
    check_eq("go_abort/start", 32'(o_start), 0);
    @(negedge clk);
    check_eq("go_abort/still_idle", 32'(o_busy), 0);

    set_cfg(60, 40, 40, 0, 1, 7, -1, 1);    run_batch("abort");
    set_cfg(60, 10, 10, 0, -1, 0, 1, 0);    run_batch("async_reset");

    for (int b = 0; b < 20; b++) begin
      int d [NUM_PROGS];
      for (int i = 0; i < NUM_PROGS; i++) begin
        d[i] = ($urandom_range(0, 7) == 0) ? 1000 : int'($urandom_range(0, 55));
      end
      set_cfg(d[0], d[1], d[2], 1'($urandom_range(0, 1)), -1, 0, -1, 1'($urandom_range(0, 1)));
      run_batch($sformatf("rand%0d", b));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/run_sequencer.md
RUN_SEQUENCER -- requirements
Module: run_sequencer

Interface
REQ-001 Parameter NUM_PROGS, default 3, is the number of programs run per batch; the legal range is 1..4.
REQ-002 Parameter START_CYCLES, default 2, is the number of cycles Start is held high per launch; the minimum is 1.
REQ-003 Parameter TIMEOUT, default 16'd10000, is the maximum run cycles allowed before a program is abandoned.
REQ-004 Clk  in  1  single clock; all state SHALL update on posedge Clk.
REQ-005 Reset  in  1  reset SHALL be asynchronous and active-high.
REQ-006 Go  in  1  SHALL begin a batch when sampled high in IDLE.
REQ-007 Abort  in  1  SHALL synchronously end the batch and return to IDLE.
REQ-008 Start  out  1  SHALL be the start request driven to the processor's Start input.
REQ-009 Ack  in  1  SHALL be the done flag returned from the processor's Ack output.
REQ-010 ProgIdx  out  2  SHALL give the index of the program currently being launched or run.
REQ-011 Busy  out  1  SHALL be high in every state except IDLE.
REQ-012 RunDone  out  1  SHALL pulse for one cycle at the end of each program, whether by Ack or by timeout.
REQ-013 Cycles  out  16  SHALL hold the run-cycle count of the most recently finished program.
REQ-014 TimedOut  out  1  SHALL be a sticky flag, high if any program in the current batch hit TIMEOUT.
REQ-015 BatchDone  out  1  SHALL pulse for one cycle when the last program finishes.

Function
REQ-016 The block SHALL implement the states IDLE, LAUNCH, RUN and NEXT.
REQ-017 IDLE: on Go=1, the block SHALL set ProgIdx=0, clear TimedOut and enter LAUNCH on the next edge.
REQ-018 LAUNCH: Start SHALL be 1 for exactly START_CYCLES consecutive cycles, then the block SHALL enter RUN.
REQ-019 LAUNCH: Ack SHALL be ignored, because a stale Ack from the previous run may still be high.
REQ-020 RUN: Start SHALL be 0; the run counter SHALL clear on entry, then increment once per cycle while Ack=0.
REQ-021 RUN: the run counter SHALL saturate at 16'hFFFF and never wrap.
REQ-022 RUN, Ack sampled 1: on that edge the block SHALL latch Cycles=count (the number of RUN cycles with Ack=0), pulse RunDone next cycle and enter NEXT.
REQ-023 RUN, count==TIMEOUT with Ack still 0: the block SHALL latch Cycles=TIMEOUT, set TimedOut, pulse RunDone and enter NEXT.
REQ-024 RUN, Ack=1 in the same cycle as count==TIMEOUT: Ack SHALL win and TimedOut SHALL NOT be set.
REQ-025 NEXT: if ProgIdx==NUM_PROGS-1, the block SHALL pulse BatchDone and enter IDLE.
REQ-026 NEXT, otherwise: the block SHALL increment ProgIdx and enter LAUNCH; NEXT SHALL last exactly one cycle.
REQ-027 Go while Busy=1 SHALL be ignored.
REQ-028 Abort=1 in any state SHALL cause Start=0 and entry to IDLE next cycle, with no RunDone or BatchDone pulse; Cycles and TimedOut SHALL retain their values.
REQ-029 Go=1 and Abort=1 together in IDLE: Abort SHALL win and the block SHALL stay in IDLE.
REQ-030 Start, RunDone and BatchDone SHALL be registered outputs with no combinational path from any input.
REQ-031 ProgIdx SHALL stay constant from LAUNCH entry until NEXT.

Reset
REQ-032 Reset=1 SHALL immediately force IDLE, Start=0, Busy=0, ProgIdx=0, RunDone=0, BatchDone=0, Cycles=0, TimedOut=0, run counter=0.
REQ-033 Reset asserted mid-LAUNCH or mid-RUN SHALL drop Start within the same cycle, asynchronously, and discard the batch.
REQ-034 After Reset deasserts, the block SHALL wait in IDLE for Go and SHALL NOT relaunch automatically.

Verification
REQ-035 Nominal: defaults, Go pulse, model raises Ack 20 cycles after Start falls for each program -> Start high for 2 cycles x3, RunDone x3 with Cycles=20, BatchDone once, TimedOut=0.
REQ-036 Stale Ack: Ack held 1 through LAUNCH, dropped at RUN entry, raised 5 cycles later -> Cycles=5, no early RunDone.
REQ-037 Timeout: TIMEOUT=16'd50, program 1 never acks -> Cycles=50, TimedOut=1, ProgIdx advances to 2, BatchDone still pulses.
REQ-038 Race: Ack rises exactly at count==TIMEOUT -> Cycles=TIMEOUT, TimedOut=0.
REQ-039 Abort at RUN cycle 7 of program 1, with a second Go issued while Busy -> IDLE next cycle, no BatchDone, Busy=0, the second Go has no effect.
REQ-040 Async reset mid-LAUNCH, between clock edges -> Start=0 before the next edge, all outputs at reset values, and the next Go starts a fresh batch at ProgIdx=0.
